// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: load/store op codes,
// default region/fairness parameters and FSM state encoding.
package mem_arbiter_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [1:0] IO_HI_DEF      = 2'b11;
    localparam int         FAIR_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // A store into the IO region may not issue while the IO write buffer is full.
    function automatic logic io_hold(input logic store, input logic [1:0] region,
                                     input logic full, input logic [1:0] io_hi);
        return store && (region == io_hi) && full;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF/LS requesters, the arbiter and the
// byte-serial memory controller. slave = arbiter side, master = environment side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_store;
    logic [31:0] ls_addr;
    logic [31:0] ls_data;
    logic [2:0]  ls_op;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic        is_fetch;
    logic [31:0] fetch_addr;
    logic        is_io;
    logic        is_store;
    logic [31:0] io_addr;
    logic [31:0] io_data;
    logic [2:0]  io_op;

    logic        is_back;
    logic [31:0] back_ins;
    logic        mem_res_avail;
    logic [31:0] mem_res;
    logic        working;
    logic        io_buffer_full;

    // Requests are levels held stable until the matching one-cycle done pulse;
    // controller strobes are one-cycle pulses, results are one-cycle valids.
    modport slave (
        input  if_req, if_addr, ls_req, ls_store, ls_addr, ls_data, ls_op,
        input  is_back, back_ins, mem_res_avail, mem_res, working, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata,
        output is_fetch, fetch_addr, is_io, is_store, io_addr, io_data, io_op
    );

    modport master (
        output if_req, if_addr, ls_req, ls_store, ls_addr, ls_data, ls_op,
        output is_back, back_ins, mem_res_avail, mem_res, working, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata,
        input  is_fetch, fetch_addr, is_io, is_store, io_addr, io_data, io_op
    );
endinterface

// File: rtl/mem_arbiter_load_ext.sv
// Sign/zero extension of a raw load word according to funct3.
module mem_arbiter_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);
    always_comb begin
        ext = raw;
        case (op)
            OP_B:    ext = {{24{raw[7]}}, raw[7:0]};
            OP_H:    ext = {{16{raw[15]}}, raw[15:0]};
            OP_BU:   ext = {24'b0, raw[7:0]};
            OP_HU:   ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the memory controller's single request port between the
// instruction fetch and load/store requesters, with bounded IF starvation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         FAIR_LIMIT = FAIR_LIMIT_DEF,
    parameter logic [1:0] IO_HI      = IO_HI_DEF
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_in,
    mem_arbiter_if.slave bus,
    output state_t       dbg_state
);
    localparam int              CNT_W   = $clog2(FAIR_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] fair_cnt;
    logic             squash;
    logic             cmd_ls, cmd_store;
    logic [31:0]      cmd_addr, cmd_data;
    logic [2:0]       cmd_op;
    logic [31:0]      ext;

    logic             if_ok, grant_ls, grant_if, strobed, done_hold, blocked, do_strobe;
    logic             nxt_ls, nxt_store;
    logic [31:0]      nxt_addr, nxt_data;
    logic [2:0]       nxt_op;

    mem_arbiter_load_ext u_load_ext (
        .op  (cmd_op),
        .raw (bus.mem_res),
        .ext (ext)
    );

    assign dbg_state = state;

    // nxt_* is the command about to be strobed: the fresh winner in IDLE,
    // the latched command afterwards.
    always_comb begin
        if_ok     = bus.if_req && !clear_in;
        grant_ls  = bus.ls_req && !(if_ok && fair_cnt == CNT_MAX);
        grant_if  = if_ok && !grant_ls;
        strobed   = bus.is_fetch || bus.is_io;
        done_hold = bus.if_done || bus.ls_done;
        if (state == ST_IDLE) begin
            nxt_ls    = grant_ls;
            nxt_store = grant_ls && bus.ls_store;
            nxt_addr  = grant_ls ? bus.ls_addr : bus.if_addr;
            nxt_data  = grant_ls ? bus.ls_data : 32'b0;
            nxt_op    = grant_ls ? bus.ls_op : 3'b0;
        end else begin
            nxt_ls    = cmd_ls;
            nxt_store = cmd_store;
            nxt_addr  = cmd_addr;
            nxt_data  = cmd_data;
            nxt_op    = cmd_op;
        end
        blocked = bus.working || io_hold(nxt_store, nxt_addr[17:16], bus.io_buffer_full, IO_HI);
        case (state)
            ST_IDLE:  do_strobe = !done_hold && (grant_ls || grant_if) && !blocked;
            ST_ISSUE: do_strobe = !strobed && !(!cmd_ls && clear_in) && !blocked;
            default:  do_strobe = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            fair_cnt       <= '0;
            squash         <= 1'b0;
            cmd_ls         <= 1'b0;
            cmd_store      <= 1'b0;
            cmd_addr       <= '0;
            cmd_data       <= '0;
            cmd_op         <= '0;
            bus.if_done    <= 1'b0;
            bus.if_data    <= '0;
            bus.ls_done    <= 1'b0;
            bus.ls_rdata   <= '0;
            bus.is_fetch   <= 1'b0;
            bus.fetch_addr <= '0;
            bus.is_io      <= 1'b0;
            bus.is_store   <= 1'b0;
            bus.io_addr    <= '0;
            bus.io_data    <= '0;
            bus.io_op      <= '0;
        end else if (rdy_in) begin
            bus.if_done  <= 1'b0;
            bus.ls_done  <= 1'b0;
            bus.is_fetch <= 1'b0;
            bus.is_io    <= 1'b0;
            bus.is_store <= 1'b0;
            if (!bus.if_req) fair_cnt <= '0;

            case (state)
                ST_IDLE: begin
                    // The done cycle is skipped so the requester can update its request.
                    if (!done_hold && (grant_ls || grant_if)) begin
                        cmd_ls    <= nxt_ls;
                        cmd_store <= nxt_store;
                        cmd_addr  <= nxt_addr;
                        cmd_data  <= nxt_data;
                        cmd_op    <= nxt_op;
                        squash    <= 1'b0;
                        if (grant_if) fair_cnt <= '0;
                        else if (bus.if_req && fair_cnt != CNT_MAX) fair_cnt <= fair_cnt + 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (strobed) begin
                        if (!cmd_ls && clear_in) squash <= 1'b1;
                        state <= ST_WAIT;
                    end else if (!cmd_ls && clear_in) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!cmd_ls && clear_in) squash <= 1'b1;
                    if (cmd_ls && bus.mem_res_avail) begin
                        bus.ls_done  <= 1'b1;
                        bus.ls_rdata <= cmd_store ? 32'b0 : ext;
                        state        <= ST_IDLE;
                    end else if (!cmd_ls && bus.is_back) begin
                        if (!squash && !clear_in) begin
                            bus.if_done <= 1'b1;
                            bus.if_data <= bus.back_ins;
                        end
                        squash <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (do_strobe) begin
                bus.is_fetch <= !nxt_ls;
                bus.is_io    <= nxt_ls;
                bus.is_store <= nxt_store;
                bus.io_addr  <= nxt_addr;
                bus.io_data  <= nxt_data;
                bus.io_op    <= nxt_op;
                if (!nxt_ls) bus.fetch_addr <= nxt_addr;
            end
        end
    end
endmodule
